// File: rtl/div_unit_pkg.sv
// Shared divider definitions: ALU control codes, FSM encodings, width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [7:0] DIV_CONTROL  = 8'b0001_1010;
  localparam logic [7:0] DIVU_CONTROL = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division step, purely combinational.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Shifted remainder needs one extra bit before the compare.
  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_i};

  always_comb begin
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the execute stage.
// DIV_ZERO_FAST_EN: zero divisor finishes in one cycle.
import div_unit_pkg::*;

module div_unit #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               sgn_q, sgn_d;
  logic               qneg_q, qneg_d;
  logic               dneg_q, dneg_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0] rem_n, quo_n;
  logic [WIDTH-1:0] rem_f, quo_f;
  logic [WIDTH-1:0] ones;
  logic             s1, s2;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_n),
    .quo_o (quo_n)
  );

  assign ones = '1;
  assign s1   = signed_i & opdata1_i[WIDTH-1];
  assign s2   = signed_i & opdata2_i[WIDTH-1];

  always_comb begin
    quo_f = (sgn_q & qneg_q) ? -quo_n : quo_n;
    rem_f = (sgn_q & dneg_q) ? -rem_n : rem_n;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    dneg_d  = dneg_q;
    ready_d = 1'b0;
    res_d   = res_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          sgn_d   = signed_i;
          dvd_d   = opdata1_i;
          quo_d   = s1 ? -opdata1_i : opdata1_i;
          dvs_d   = s2 ? -opdata2_i : opdata2_i;
          dneg_d  = s1;
          qneg_d  = s1 ^ s2;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = DIV_BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (opdata2_i == '0) begin
            state_d = DIV_DONE;
            ready_d = 1'b1;
            res_d   = {opdata1_i, ones};
          end
`endif
        end
      end
      DIV_BUSY: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = DIV_DONE;
            ready_d = 1'b1;
            if (dvs_q == '0) begin
              res_d = {dvd_q, ones};
            end else begin
              res_d = {rem_f, quo_f};
            end
          end
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      dneg_q  <= 1'b0;
      ready_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      dneg_q  <= dneg_d;
      ready_q <= ready_d;
      res_q   <= res_d;
    end
  end

  assign ready_o  = ready_q;
  assign result_o = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit against a plain-arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [63:0] result_o;
  logic        ready_o;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (op1),
    .opdata2_i (op2),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  typedef struct {
    logic [63:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] last_res = '0;

  function automatic logic [63:0] ref_div(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    longint x, y, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; leaves start_i high on return.
  task automatic do_div(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    exp_t e;
    int   lat;
    lat      = (b == 32'd0) ? ZLAT : 33;
    start_i  = 1'b1;
    signed_i = s;
    op1      = a;
    op2      = b;
    e.res    = ref_div(a, b, s);
    e.cyc    = cyc + lat;
    sb.push_back(e);
    for (int i = 0; i < lat + 1; i++) begin
      @(negedge clk);
      op1      = $urandom;
      op2      = $urandom;
      signed_i = 1'($urandom);
    end
  endtask

  task automatic drain();
    start_i = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    #1;
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 0", ready_o);
    end
    n_cmp++;
    if (result_o !== 64'd0) begin
      n_bad++;
      $display("FAIL rst_result: got %h want 0", result_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (sb.size() != 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_missing: got none want cycle %0d",
                     sb[0].cyc);
            last_res = sb[0].res;
            void'(sb.pop_front());
          end
          n_cmp++;
          if (ready_o) begin
            if (sb.size() == 0) begin
              n_bad++;
              $display("FAIL spurious_ready: got ready cycle %0d want none",
                       cyc);
            end else begin
              e = sb.pop_front();
              last_res = e.res;
              if (cyc != e.cyc) begin
                n_bad++;
                $display("FAIL ready_cycle: got %0d want %0d", cyc, e.cyc);
              end else if (result_o !== e.res) begin
                n_bad++;
                $display("FAIL result: got %h want %h", result_o, e.res);
              end
            end
          end else if (result_o !== last_res) begin
            n_bad++;
            $display("FAIL hold: got %h want %h", result_o, last_res);
          end
        end
      end
      begin
        @(negedge clk);
        do_div(32'd100, 32'd7, 1'b0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(32'h1234_5678, 32'd0, 1'b1);
        do_div(32'h1234_5678, 32'd0, 1'b0);
        start_i = 1'b0;
        @(negedge clk);
        // Abort in cycle 10, restart in cycle 12.
        start_i  = 1'b1;
        signed_i = 1'b0;
        op1      = 32'd1000;
        op2      = 32'd3;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        do_div(32'd1000, 32'd3, 1'b0);
        start_i = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
          do_div(rand_op(), rand_op(), 1'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            start_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
          end
        end
        drain();
        do_div(32'd100, 32'd7, 1'b0);
        drain();
        start_i  = 1'b1;
        signed_i = 1'b1;
        op1      = 32'hDEAD_BEEF;
        op2      = 32'd5;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        n_cmp++;
        if (result_o !== 64'd0 || ready_o !== 1'b0) begin
          n_bad++;
          $display("FAIL async_rst: got %h/%b want 0/0", result_o, ready_o);
        end
        last_res = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drain();
        do_div(32'hFFFF_FF00, 32'd16, 1'b1);
        drain();
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
